// File: rtl/fifo_pkg.sv
// Shared FIFO constants: read-mode selectors and default flag thresholds.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int FIFO_AEMPTY_DEFAULT = 4;
  localparam int FIFO_AFULL_MARGIN   = 4;

  function automatic int afull_default(input int addr_width);
    return (1 << addr_width) - FIFO_AFULL_MARGIN;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one write port, one read port, registered or asynchronous read.
module fifo_dpram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int REG_READ   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      // Only the output register is reset; it holds between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end else begin : g_async_read
      assign rdata = mem[raddr];
      logic unused_ok;
      assign unused_ok = &{1'b0, re, rst_n};
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with count-decoded status flags, sticky error flags and
// selectable registered or first-word-fall-through read.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int FWFT         = FIFO_MODE_STD,
  parameter int AFULL_LEVEL  = afull_default(ADDR_WIDTH),
  parameter int AEMPTY_LEVEL = FIFO_AEMPTY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] ram_q;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A fresh error in the clearing cycle takes priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !err_clr) || (wr_en && !wr_acc);
      underflow <= (underflow && !err_clr) || (rd_en && empty);
    end
  end

  fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_READ   ((FWFT == FIFO_MODE_FWFT) ? 0 : 1)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is shown directly; masked while empty so reset reads as zero.
      assign data_out   = empty ? '0 : ram_q;
      assign data_valid = !empty;
    end else begin : g_std
      assign data_out = ram_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_valid <= 1'b0;
        else        data_valid <= rd_acc;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one standard-read and one FWFT instance, depth 4.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr0 = 0, rd0 = 0, clr0 = 0;
  logic [7:0] din0 = '0, dout0;
  logic       dv0, e0, f0, ae0, af0, ovf0, udf0;
  logic [2:0] cnt0;

  logic       wr1 = 0, rd1 = 0, clr1 = 0;
  logic [7:0] din1 = '0, dout1;
  logic       dv1, e1, f1, ae1, af1, ovf1, udf1;
  logic [2:0] cnt1;

  sync_fifo_flags #(
    .DATA_WIDTH (8), .ADDR_WIDTH (2), .FWFT (0), .AFULL_LEVEL (3), .AEMPTY_LEVEL (1)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .wr_en (wr0), .data_in (din0), .rd_en (rd0),
    .data_out (dout0), .data_valid (dv0), .empty (e0), .full (f0),
    .almost_empty (ae0), .almost_full (af0), .count (cnt0),
    .overflow (ovf0), .underflow (udf0), .err_clr (clr0)
  );

  sync_fifo_flags #(
    .DATA_WIDTH (8), .ADDR_WIDTH (2), .FWFT (1), .AFULL_LEVEL (3), .AEMPTY_LEVEL (1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .wr_en (wr1), .data_in (din1), .rd_en (rd1),
    .data_out (dout1), .data_valid (dv1), .empty (e1), .full (f1),
    .almost_empty (ae1), .almost_full (af1), .count (cnt1),
    .overflow (ovf1), .underflow (udf1), .err_clr (clr1)
  );

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    int         cnt;
    logic       e, f, ae, af, dv;
    logic [7:0] dout;
    logic       ovf, udf;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic wr, logic rd, logic clr, logic [7:0] din, int cnt,
                              logic e, logic f, logic ae, logic af, logic dv,
                              logic [7:0] dout, logic ovf, logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt;
    v.e = e; v.f = f; v.ae = ae; v.af = af; v.dv = dv;
    v.dout = dout; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [7:0] sq[$];
  logic [7:0] exp_pop;
  logic       do_rd, do_wr;
  int         nw, nr;

  initial begin
    //            wr rd clr din    cnt e  f  ae af dv dout   ovf udf
    tv.push_back(mk(1, 0, 0, 8'h11, 1, 0, 0, 1, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h33, 3, 0, 0, 0, 1, 0, 8'h00, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h44, 4, 0, 1, 0, 1, 0, 8'h00, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h55, 4, 0, 1, 0, 1, 0, 8'h00, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 3, 0, 0, 0, 1, 1, 8'h11, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 1, 8'h22, 1, 0));
    tv.push_back(mk(0, 0, 0, 8'h00, 2, 0, 0, 0, 0, 0, 8'h22, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h33, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 8'h44, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h44, 1, 1));
    tv.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 8'h44, 0, 0));
    tv.push_back(mk(1, 1, 0, 8'h66, 1, 0, 0, 1, 0, 0, 8'h44, 0, 1));
    tv.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 1, 0, 1, 8'h66, 0, 0));
    tv.push_back(mk(0, 1, 1, 8'h00, 0, 1, 0, 1, 0, 0, 8'h66, 0, 1));
    tv.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 8'h66, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h01, 1, 0, 0, 1, 0, 0, 8'h66, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h02, 2, 0, 0, 0, 0, 0, 8'h66, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h03, 3, 0, 0, 0, 1, 0, 8'h66, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h04, 4, 0, 1, 0, 1, 0, 8'h66, 0, 0));
    tv.push_back(mk(1, 1, 0, 8'h05, 4, 0, 1, 0, 1, 1, 8'h01, 0, 0));
    tv.push_back(mk(1, 1, 0, 8'h06, 4, 0, 1, 0, 1, 1, 8'h02, 0, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 3, 0, 0, 0, 1, 1, 8'h03, 0, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 1, 8'h04, 0, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h05, 0, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 8'h06, 0, 0));

    // Reset state of both instances while rst_n is held low.
    repeat (2) tick();
    chk("rst_cnt0", cnt0, 0);   chk("rst_empty0", e0, 1);  chk("rst_aempty0", ae0, 1);
    chk("rst_full0", f0, 0);    chk("rst_dv0", dv0, 0);    chk("rst_dout0", dout0, 0);
    chk("rst_ovf0", ovf0, 0);   chk("rst_udf0", udf0, 0);
    chk("rst_cnt1", cnt1, 0);   chk("rst_empty1", e1, 1);  chk("rst_dv1", dv1, 0);
    chk("rst_dout1", dout1, 0);
    rst_n = 1'b1;
    tick();

    foreach (tv[i]) begin
      wr0 = tv[i].wr; rd0 = tv[i].rd; clr0 = tv[i].clr; din0 = tv[i].din;
      tick();
      chk($sformatf("v%0d_cnt", i),   cnt0, tv[i].cnt);
      chk($sformatf("v%0d_empty", i), e0, tv[i].e);
      chk($sformatf("v%0d_full", i),  f0, tv[i].f);
      chk($sformatf("v%0d_aempty", i), ae0, tv[i].ae);
      chk($sformatf("v%0d_afull", i), af0, tv[i].af);
      chk($sformatf("v%0d_dv", i),    dv0, tv[i].dv);
      chk($sformatf("v%0d_dout", i),  dout0, tv[i].dout);
      chk($sformatf("v%0d_ovf", i),   ovf0, tv[i].ovf);
      chk($sformatf("v%0d_udf", i),   udf0, tv[i].udf);
    end
    wr0 = 0; rd0 = 0; clr0 = 0;

    // Stream 10 words with interleaved reads so both pointers wrap.
    nw = 0; nr = 0;
    for (int c = 0; c < 40 && nr < 10; c++) begin
      do_rd = (sq.size() > 0) && (c % 3 != 0);
      do_wr = (nw < 10) && (sq.size() < 4 || do_rd);
      wr0 = do_wr; rd0 = do_rd; din0 = 8'hA0 + 8'(nw);
      tick();
      if (do_rd) begin
        exp_pop = sq.pop_front();
        nr++;
      end
      if (do_wr) begin
        sq.push_back(8'hA0 + 8'(nw));
        nw++;
      end
      chk("stream_dv", dv0, do_rd);
      if (do_rd) chk("stream_dout", dout0, exp_pop);
      chk("stream_cnt", cnt0, sq.size());
    end
    wr0 = 0; rd0 = 0;
    chk("stream_reads", nr, 10);
    chk("stream_ovf", ovf0, 0);

    // Fill past full, then drop reset between clock edges.
    for (int i = 0; i < 5; i++) begin
      wr0 = 1; din0 = 8'hC0 + 8'(i);
      tick();
    end
    chk("pre_rst_ovf", ovf0, 1);
    chk("pre_rst_full", f0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", cnt0, 0);   chk("arst_empty", e0, 1);  chk("arst_full", f0, 0);
    chk("arst_afull", af0, 0);  chk("arst_ovf", ovf0, 0);  chk("arst_dv", dv0, 0);
    chk("arst_dout", dout0, 0); chk("arst_udf", udf0, 0);
    wr0 = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_cnt", cnt0, 0);
    chk("post_rst_ovf", ovf0, 0);
    rd0 = 1;
    tick();
    rd0 = 0;
    chk("post_rst_rd_udf", udf0, 1);
    chk("post_rst_rd_dv", dv0, 0);
    clr0 = 1;
    tick();
    clr0 = 0;

    // First-word-fall-through instance.
    wr1 = 1; din1 = 8'hA5;
    tick();
    wr1 = 0;
    chk("fwft_dout", dout1, 8'hA5);
    chk("fwft_dv", dv1, 1);
    chk("fwft_empty", e1, 0);
    chk("fwft_cnt", cnt1, 1);
    rd1 = 1;
    tick();
    rd1 = 0;
    chk("fwft_ack_empty", e1, 1);
    chk("fwft_ack_dv", dv1, 0);
    chk("fwft_ack_udf", udf1, 0);
    wr1 = 1; din1 = 8'hB1;
    tick();
    din1 = 8'hB2;
    tick();
    wr1 = 0;
    chk("fwft_head1", dout1, 8'hB1);
    chk("fwft_cnt2", cnt1, 2);
    rd1 = 1;
    tick();
    chk("fwft_head2", dout1, 8'hB2);
    chk("fwft_dv2", dv1, 1);
    chk("fwft_cnt1", cnt1, 1);
    tick();
    rd1 = 0;
    chk("fwft_drained", e1, 1);
    rd1 = 1;
    tick();
    rd1 = 0;
    chk("fwft_udf", udf1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
